packet_history_mp: RTL and testbench
====================================

PACKET_HISTORY_MP -- requirements
Module: packet_history_mp

Interface
REQ-001 C_AXIS_DATA_WIDTH, 512, m/s AXIS tdata width (multiple of 64).
REQ-002 C_AXIS_TUSER_WIDTH, 128, m/s AXIS tuser width.
REQ-003 TUPLE_WIDTH, 112, flow tuple width.
REQ-004 HISTORY_DEPTH, 16, entries per port ring; power of 2, 2..64.
REQ-005 NUM_PORTS, 4, history rings; source port i is tuser bit 16+2i.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 axis_aclk  in  1  clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 s_axis_tdata/tkeep/tuser/tvalid/tlast  in  per params  ingress AXIS.
REQ-010 s_axis_tready  out  1  ingress ready.
REQ-011 s_tuple  in  TUPLE_WIDTH  packet's tuple; sampled with the first beat.
REQ-012 m_axis_tdata/tkeep/tuser/tvalid/tlast  out  per params  egress AXIS.
REQ-013 m_axis_tready  in  1  egress ready.
REQ-014 hist_clear  in  1  pulse; clears all rings.

Function
REQ-015 Every packet is preceded by H = ceil((32 + HISTORY_DEPTH*TUPLE_WIDTH)/C_AXIS_DATA_WIDTH) header beats (4 at defaults).
REQ-016 Header bits [7:0] = write ptr, [15:8] = valid count (saturates at HISTORY_DEPTH), [23:16] = port index, [31:24] = 0.
REQ-017 Entry i (oldest first, i < count) sits at bit 32+i*TUPLE_WIDTH; unused bits are 0; header tkeep is all ones, tlast 0, tuser equals the packet's first-beat tuser.
REQ-018 Port index is the lowest set source bit; if none is set, port = 0xFF, entries = 0, and no ring is updated.
REQ-019 FSM IDLE -> HEADER on s_axis_tvalid; latch tuser, s_tuple, port; s_axis_tready = 0 in IDLE and HEADER.
REQ-020 HEADER -> PAYLOAD after the H-th header handshake; PAYLOAD -> IDLE on the tlast handshake.
REQ-021 In PAYLOAD, beats pass unmodified through one output register; s_axis_tready = m_axis_tready OR output register empty.
REQ-022 The first header beat is valid one cycle after s_axis_tvalid is sampled in IDLE; throughput is one beat per cycle.
REQ-023 m_axis_tvalid, once high, holds with stable data until m_axis_tready.
REQ-024 On the tlast handshake, the latched tuple is written to ring[port][ptr], ptr increments modulo HISTORY_DEPTH, and count saturates; a back-to-back next packet sees this entry.
REQ-025 hist_clear in IDLE zeroes all pointers and counts the next cycle.
REQ-026 hist_clear in HEADER or PAYLOAD is deferred until the packet completes; the completing packet's own write is discarded.
REQ-027 A tuple wider than the header remainder is never split; H accounts for all entries.

Reset
REQ-028 Reset gives state IDLE, m_axis_tvalid = 0, m_axis_tdata/tkeep/tuser/tlast = 0, s_axis_tready = 0, and all ptr/count = 0.
REQ-029 Reset mid-packet drops the partial packet with no ring update; ring data contents need not clear.

Configuration
REQ-030 With PKT_HIST_REFLECT_EN defined, header and payload tuser destination bits [31:24] are replaced by the source one-hot shifted to the destination field; port 0xFF leaves them unchanged.
REQ-031 Without PKT_HIST_REFLECT_EN, tuser is forwarded unchanged.

Structure
REQ-032 Package packet_history_pkg holds the FSM state enum, header field offsets/widths, the SRC_PORT_POS=16 and DST_PORT_POS=24 constants, and the H computation function.
REQ-033 Sub-module packet_history_ring (one instance per port) holds a tuple RAM plus ptr/count, with a write port, a clear input, and a combinational oldest-first read-out.

Verification
REQ-034 Defaults: 3 packets on port 1 with tuples T1..T3 -> third header has count = 2, ptr = 2, entries T1, T2, and the rest zero.
REQ-035 17 packets on port 0 -> 18th header has count = 16, ptr = 1, oldest entry = tuple #2, newest = #17.
REQ-036 Interleave port 0 and port 2 -> each header contains only its own port's tuples.
REQ-037 Random m_axis_tready (50%) over a 9-beat packet -> 4 + 9 beats out, no drop or duplicate, tvalid held stable.
REQ-038 hist_clear during PAYLOAD -> next header has count = 0, ptr = 0.
REQ-039 REFLECT_EN with tuser bit 18 set -> output tuser bit 26 is set on all beats; tuser with no source bit -> port field 0xFF.

Source files
------------

// File: rtl/packet_history_pkg.sv
// Shared types and constants for the per-port packet history inserter.
// Holds the FSM state encoding, header field layout, tuser port-bit positions
// and the function that sizes the history header in data beats.
package packet_history_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  // Header layout: fixed 32-bit preamble followed by the tuple entries.
  localparam int HDR_FIELD_W  = 8;
  localparam int HDR_PTR_LSB  = 0;
  localparam int HDR_CNT_LSB  = 8;
  localparam int HDR_PORT_LSB = 16;
  localparam int HDR_FIXED_W  = 32;

  // tuser port fields: source port i is bit SRC_PORT_POS+2i, destination likewise.
  localparam int SRC_PORT_POS = 16;
  localparam int DST_PORT_POS = 24;

  localparam logic [7:0] PORT_NONE = 8'hFF;

  // Whole beats needed for the preamble plus every possible entry; entries are
  // packed contiguously so no tuple is ever split across an unused remainder.
  function automatic int hdr_beats(input int data_w, input int depth, input int tuple_w);
    return (HDR_FIXED_W + depth * tuple_w + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/packet_history_ring.sv
// One port's history ring: tuple RAM plus write pointer and saturating count.
// Ports: clk/reset, clear (zeroes ptr/count), wr_en/wr_tuple (append),
//        ptr/count (8-bit views), entries (oldest-first, unused slots zero).
module packet_history_ring #(
  parameter int TUPLE_WIDTH   = 112,
  parameter int HISTORY_DEPTH = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic                                   wr_en,
  input  logic [TUPLE_WIDTH-1:0]                 wr_tuple,
  output logic [7:0]                             ptr,
  output logic [7:0]                             count,
  output logic [HISTORY_DEPTH*TUPLE_WIDTH-1:0]   entries
);

  localparam int PW = $clog2(HISTORY_DEPTH);

  logic [TUPLE_WIDTH-1:0] ram [HISTORY_DEPTH];
  logic [PW-1:0]          ptr_q;
  logic [PW:0]            cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (wr_en) begin
      ptr_q <= ptr_q + PW'(1);
      if (cnt_q != (PW+1)'(HISTORY_DEPTH)) begin
        cnt_q <= cnt_q + (PW+1)'(1);
      end
    end
  end

  // Contents are left as-is on reset/clear; count gates what is visible.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      ram[ptr_q] <= wr_tuple;
    end
  end

  assign ptr   = 8'(ptr_q);
  assign count = 8'(cnt_q);

  // Oldest entry lives at ptr - count (mod depth); this also covers the full
  // case, where the low bits of count are zero and the oldest is at ptr.
  always_comb begin
    entries = '0;
    for (int i = 0; i < HISTORY_DEPTH; i++) begin
      if (i < int'(cnt_q)) begin
        entries[i*TUPLE_WIDTH +: TUPLE_WIDTH] = ram[ptr_q - cnt_q[PW-1:0] + PW'(i)];
      end
    end
  end

endmodule

// File: rtl/packet_history_mp.sv
// Prepends a per-source-port flow history header to each AXIS packet, then logs its tuple.
// Ports: axis_aclk/reset, s_axis_* + s_tuple ingress, m_axis_* egress, hist_clear pulse.
// Optional macro PKT_HIST_REFLECT_EN: rewrite tuser destination bits from the source port.
module packet_history_mp
  import packet_history_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int TUPLE_WIDTH        = 112,
  parameter int HISTORY_DEPTH      = 16,
  parameter int NUM_PORTS          = 4
) (
  input  logic                            axis_aclk,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  input  logic [TUPLE_WIDTH-1:0]          s_tuple,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic                            hist_clear
);

  localparam int H        = hdr_beats(C_AXIS_DATA_WIDTH, HISTORY_DEPTH, TUPLE_WIDTH);
  localparam int DW       = C_AXIS_DATA_WIDTH;
  localparam int HDR_BITS = H * DW;
  localparam int ENT_BITS = HISTORY_DEPTH * TUPLE_WIDTH;

  state_t                          state;
  logic [7:0]                      hdr_cnt;     // header beats loaded so far
  logic [7:0]                      port_q;
  logic [C_AXIS_TUSER_WIDTH-1:0]   tuser_q;
  logic [TUPLE_WIDTH-1:0]          tuple_q;
  logic                            clear_pend;

  logic [7:0]                      port_in;
  logic [7:0]                      sel_port;
  logic [7:0]                      hdr_idx;
  logic [C_AXIS_TUSER_WIDTH-1:0]   sel_user;
  logic [C_AXIS_TUSER_WIDTH-1:0]   hdr_user;
  logic [C_AXIS_TUSER_WIDTH-1:0]   pay_user;
  logic [HDR_BITS-1:0]             hdr_vec;
  logic [DW-1:0]                   hdr_beat;
  logic                            out_free;
  logic                            s_hs;
  logic                            tlast_hs;
  logic                            ring_clr;
  logic [NUM_PORTS-1:0]            ring_wr;
  logic [7:0]                      ring_ptr [NUM_PORTS];
  logic [7:0]                      ring_cnt [NUM_PORTS];
  logic [ENT_BITS-1:0]             ring_ent [NUM_PORTS];

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == ST_PAYLOAD) && out_free;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign tlast_hs      = s_hs && s_axis_tlast;

  // A clear seen mid-packet is held until tlast and then wins over that
  // packet's own write.
  assign ring_clr = ((state == ST_IDLE) && hist_clear) ||
                    (tlast_hs && (clear_pend || hist_clear));

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ring
    assign ring_wr[p] = tlast_hs && !clear_pend && !hist_clear && (port_q == 8'(p));

    packet_history_ring #(
      .TUPLE_WIDTH   (TUPLE_WIDTH),
      .HISTORY_DEPTH (HISTORY_DEPTH)
    ) u_ring (
      .clk      (axis_aclk),
      .reset    (reset),
      .clear    (ring_clr),
      .wr_en    (ring_wr[p]),
      .wr_tuple (tuple_q),
      .ptr      (ring_ptr[p]),
      .count    (ring_cnt[p]),
      .entries  (ring_ent[p])
    );
  end

  // Lowest set source bit wins.
  always_comb begin
    port_in = PORT_NONE;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (s_axis_tuser[SRC_PORT_POS + 2*p]) port_in = 8'(p);
    end
  end

  // In IDLE the first header beat is built straight from the incoming beat,
  // since nothing has been latched yet.
  always_comb begin
    sel_port = (state == ST_IDLE) ? port_in : port_q;
    sel_user = (state == ST_IDLE) ? s_axis_tuser : tuser_q;
    hdr_idx  = (state == ST_IDLE) ? 8'd0 : hdr_cnt;
    hdr_vec  = '0;
    hdr_vec[HDR_PORT_LSB +: HDR_FIELD_W] = sel_port;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel_port == 8'(p)) begin
        hdr_vec[HDR_PTR_LSB +: HDR_FIELD_W] = ring_ptr[p];
        hdr_vec[HDR_CNT_LSB +: HDR_FIELD_W] = ring_cnt[p];
        hdr_vec[HDR_FIXED_W +: ENT_BITS]    = ring_ent[p];
      end
    end
  end

  always_comb begin
    hdr_beat = '0;
    for (int k = 0; k < H; k++) begin
      if (hdr_idx == 8'(k)) hdr_beat = hdr_vec[k*DW +: DW];
    end
  end

  always_comb begin
    hdr_user = sel_user;
    pay_user = s_axis_tuser;
`ifdef PKT_HIST_REFLECT_EN
    if (sel_port != PORT_NONE) begin
      hdr_user[DST_PORT_POS +: 8] = 8'(32'd1 << (2 * int'(sel_port)));
    end
    if (port_q != PORT_NONE) begin
      pay_user[DST_PORT_POS +: 8] = 8'(32'd1 << (2 * int'(port_q)));
    end
`endif
  end

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      state         <= ST_IDLE;
      hdr_cnt       <= '0;
      port_q        <= PORT_NONE;
      tuser_q       <= '0;
      tuple_q       <= '0;
      clear_pend    <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      // Drain by default; any load below overrides.
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      case (state)
        ST_IDLE: begin
          // A clear in the same cycle goes first so the header never mixes
          // pre- and post-clear ring state; the packet starts a cycle later.
          if (s_axis_tvalid && !hist_clear && out_free) begin
            port_q        <= port_in;
            tuser_q       <= s_axis_tuser;
            tuple_q       <= s_tuple;
            clear_pend    <= 1'b0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hdr_beat;
            m_axis_tkeep  <= '1;
            m_axis_tuser  <= hdr_user;
            m_axis_tlast  <= 1'b0;
            hdr_cnt       <= 8'd1;
            state         <= ST_HEADER;
          end
        end

        ST_HEADER: begin
          if (hist_clear) clear_pend <= 1'b1;
          if (out_free) begin
            if (hdr_cnt < 8'(H)) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= hdr_beat;
              m_axis_tkeep  <= '1;
              m_axis_tuser  <= hdr_user;
              m_axis_tlast  <= 1'b0;
              hdr_cnt       <= hdr_cnt + 8'd1;
            end else begin
              // Last header beat is being accepted this cycle.
              state <= ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (hist_clear) clear_pend <= 1'b1;
          if (s_hs) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tuser  <= pay_user;
            m_axis_tlast  <= s_axis_tlast;
            if (s_axis_tlast) begin
              clear_pend <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_history_mp.sv
// Scoreboard bench for packet_history_mp: a driver pushes expected beats from a
// queue-based history model, an independent monitor pops and compares on each
// egress handshake and checks that stalled outputs stay stable.
module tb_packet_history_mp;

  localparam int DW = 512;
  localparam int UW = 128;
  localparam int TW = 112;
  localparam int D  = 16;
  localparam int NP = 4;
  localparam int KW = DW / 8;
  localparam int HB = 4;   // ceil((32 + 16*112) / 512)

  logic           axis_aclk = 1'b0;
  logic           reset = 1'b1;
  logic [DW-1:0]  s_axis_tdata;
  logic [KW-1:0]  s_axis_tkeep;
  logic [UW-1:0]  s_axis_tuser;
  logic           s_axis_tvalid;
  logic           s_axis_tlast;
  logic           s_axis_tready;
  logic [TW-1:0]  s_tuple;
  logic [DW-1:0]  m_axis_tdata;
  logic [KW-1:0]  m_axis_tkeep;
  logic [UW-1:0]  m_axis_tuser;
  logic           m_axis_tvalid;
  logic           m_axis_tlast;
  logic           m_axis_tready;
  logic           hist_clear;

  always #5 axis_aclk = ~axis_aclk;

  packet_history_mp dut (
    .axis_aclk     (axis_aclk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .s_tuple       (s_tuple),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .hist_clear    (hist_clear)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_out = 0;
  int            n_pushed = 0;
  bit            rdy_random = 1'b0;

  // Reference history: per port, the last D tuples oldest first, plus total writes.
  logic [TW-1:0] hist [NP][$];
  int            wr_total [NP];

  function automatic int src_port(input logic [UW-1:0] u);
    for (int p = 0; p < NP; p++) if (u[16 + 2*p]) return p;
    return -1;
  endfunction

  function automatic logic [UW-1:0] exp_user(input logic [UW-1:0] u);
    logic [UW-1:0] r;
    int p;
    r = u;
    p = src_port(u);
`ifdef PKT_HIST_REFLECT_EN
    if (p >= 0) r[31:24] = 8'(1 << (2*p));
`else
    if (p < -1) r = '0;
`endif
    return r;
  endfunction

  function automatic logic [TW-1:0] rand_tuple();
    logic [127:0] x;
    x = {$urandom(), $urandom(), $urandom(), $urandom()};
    return x[TW-1:0];
  endfunction

  function automatic logic [UW-1:0] mk_user(input int p);
    logic [UW-1:0] u;
    u = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int q = 0; q < NP; q++) u[16 + 2*q] = 1'b0;
    if (p >= 0) u[16 + 2*p] = 1'b1;
    return u;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NP; p++) begin
      hist[p].delete();
      wr_total[p] = 0;
    end
  endtask

  task automatic model_write(input logic [UW-1:0] u, input logic [TW-1:0] t);
    int p;
    p = src_port(u);
    if (p >= 0) begin
      hist[p].push_back(t);
      if (hist[p].size() > D) void'(hist[p].pop_front());
      wr_total[p]++;
    end
  endtask

  task automatic push_beat(input beat_t b);
    exp_q.push_back(b);
    n_pushed++;
  endtask

  task automatic push_header(input logic [UW-1:0] u);
    logic [HB*DW-1:0] h;
    beat_t b;
    int p;
    h = '0;
    p = src_port(u);
    if (p < 0) begin
      h[23:16] = 8'hFF;
    end else begin
      h[7:0]   = 8'(wr_total[p] % D);
      h[15:8]  = 8'(hist[p].size());
      h[23:16] = 8'(p);
      for (int i = 0; i < hist[p].size(); i++) h[32 + i*TW +: TW] = hist[p][i];
    end
    for (int k = 0; k < HB; k++) begin
      b.d = h[k*DW +: DW];
      b.k = '1;
      b.u = exp_user(u);
      b.l = 1'b0;
      push_beat(b);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic wait_handshake();
    int g;
    g = 0;
    do begin
      @(negedge axis_aclk);
      g++;
      if (g > 5000) begin
        n_cmp++;
        n_err++;
        $display("FAIL handshake_timeout got no s_axis_tready in %0d cycles, required ready", g);
        finish_run();
      end
    end while (!s_axis_tready);
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic send_packet(input logic [UW-1:0] u, input logic [TW-1:0] t,
                             input int nbeats, input bit clear_mid);
    beat_t b;
    push_header(u);
    s_tuple      = t;
    s_axis_tuser = u;
    for (int i = 0; i < nbeats; i++) begin
      for (int w = 0; w < DW/32; w++) b.d[w*32 +: 32] = $urandom();
      b.k = {$urandom(), $urandom()};
      b.u = exp_user(u);
      b.l = (i == nbeats - 1);
      push_beat(b);
      s_axis_tdata  = b.d;
      s_axis_tkeep  = b.k;
      s_axis_tlast  = b.l;
      s_axis_tvalid = 1'b1;
      wait_handshake();
      s_axis_tvalid = 1'b0;
      if (clear_mid && i == 0) begin
        hist_clear = 1'b1;
        @(posedge axis_aclk);
        #1;
        hist_clear = 1'b0;
      end
    end
    if (clear_mid) model_clear();
    else model_write(u, t);
  endtask

  // Egress ready: always-on or 50% random, changed just after each edge.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge axis_aclk);
      #1;
      m_axis_tready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare every accepted beat, and check stalled beats stay put.
  initial begin
    beat_t got;
    beat_t e;
    beat_t held;
    bit    stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge axis_aclk);
      if (reset) begin
        stall = 1'b0;
        continue;
      end
      got = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
      if (stall) begin
        n_cmp++;
        if (!m_axis_tvalid || got !== held) begin
          n_err++;
          $display("FAIL hold_stable beat %0d valid %b data %0h, required valid 1 data %0h",
                   n_out, m_axis_tvalid, got.d, held.d);
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held  = got;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat %0d data %0h, required no beat", n_out, got.d);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (got.d !== e.d) begin
            n_err++;
            $display("FAIL beat%0d_data got %0h required %0h", n_out, got.d, e.d);
          end
          n_cmp++;
          if ({got.k, got.u, got.l} !== {e.k, e.u, e.l}) begin
            n_err++;
            $display("FAIL beat%0d_keep_user_last got %0h/%0h/%b required %0h/%0h/%b",
                     n_out, got.k, got.u, got.l, e.k, e.u, e.l);
          end
        end
        n_out++;
      end
    end
  end

  initial begin
    int g;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_tuple       = '0;
    hist_clear    = 1'b0;
    model_clear();

    reset = 1'b1;
    repeat (5) @(posedge axis_aclk);
    #1;
    chk("rst_m_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("rst_m_tdata",  128'(m_axis_tdata != '0), 128'd0);
    chk("rst_m_tkeep",  128'(m_axis_tkeep), 128'd0);
    chk("rst_m_tuser",  m_axis_tuser, 128'd0);
    chk("rst_m_tlast",  128'(m_axis_tlast), 128'd0);
    chk("rst_s_tready", 128'(s_axis_tready), 128'd0);
    reset = 1'b0;
    @(posedge axis_aclk);
    #1;

    // Three packets on port 1: third header shows the first two tuples.
    for (int i = 0; i < 3; i++) send_packet(mk_user(1), rand_tuple(), 2, 1'b0);

    // Port 0 wraps: 18th header has full count, ptr 1, oldest = tuple #2.
    for (int i = 0; i < 18; i++) send_packet(mk_user(0), rand_tuple(), 1 + i % 3, 1'b0);

    // Interleaved ports 0 and 2 keep separate histories.
    for (int i = 0; i < 8; i++) send_packet(mk_user((i % 2) ? 2 : 0), rand_tuple(), 2, 1'b0);

    // 9-beat packet under 50% egress ready.
    rdy_random = 1'b1;
    send_packet(mk_user(3), rand_tuple(), 9, 1'b0);

    // Clear while in payload: that packet's write is dropped, next header empty.
    send_packet(mk_user(1), rand_tuple(), 3, 1'b1);
    send_packet(mk_user(1), rand_tuple(), 2, 1'b0);
    send_packet(mk_user(1), rand_tuple(), 2, 1'b0);

    // No source bit: port 0xFF, no history update.
    send_packet(mk_user(-1), rand_tuple(), 2, 1'b0);
    send_packet(mk_user(2), rand_tuple(), 1, 1'b0);

    // Clear while idle.
    hist_clear = 1'b1;
    @(posedge axis_aclk);
    #1;
    hist_clear = 1'b0;
    model_clear();
    send_packet(mk_user(2), rand_tuple(), 2, 1'b0);

    // Random mix: any source bits (lowest wins), lengths and ready pattern.
    for (int i = 0; i < 40; i++) begin
      logic [UW-1:0] u;
      u = {$urandom(), $urandom(), $urandom(), $urandom()};
      rdy_random = 1'($urandom_range(0, 1));
      send_packet(u, rand_tuple(), $urandom_range(1, 6), ($urandom_range(0, 9) == 0));
    end

    rdy_random = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge axis_aclk);
      g++;
    end
    repeat (4) @(negedge axis_aclk);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    chk("beat_total",    128'(n_out), 128'(n_pushed));
    finish_run();
  end

endmodule
